// File: rtl/if_id_buffer.sv
// IF/ID elastic buffer: a DEPTH-entry circular FIFO of {instr, pc} with valid/ready on both sides,
// flush to empty, NOP on an empty head, plus a saturating stall counter and a sticky misaligned-PC flag.
module if_id_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter logic [31:0] NOP   = 32'hC8000000,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_pc,
   output logic             out_is_branch,
   output logic [CNT_W-1:0] stall_count,
   output logic             misalign
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;

   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      pc_q    [DEPTH];
   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             misalign_q, misalign_d;
   logic             push, pop;

   assign in_ready  = (count_q < FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      stall_d    = stall_q;
      // A push discarded by a flush still reports its misaligned pc.
      misalign_d = misalign_q | (push & (in_pc[1:0] != 2'b00));
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_t'(wr_ptr_q + 1'b1);
         if (pop)  rd_ptr_d = ptr_t'(rd_ptr_q + 1'b1);
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         stall_q    <= '0;
         misalign_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         stall_q    <= stall_d;
         misalign_q <= misalign_d;
         if (push && !flush) begin
            instr_q[wr_ptr_q] <= in_instr;
            pc_q[wr_ptr_q]    <= in_pc;
         end
      end
   end

   assign out_instr     = out_valid ? instr_q[rd_ptr_q] : NOP;
   assign out_pc        = out_valid ? pc_q[rd_ptr_q] : '0;
   assign out_is_branch = out_valid &&
                          ((out_instr[31:25] == 7'b1100000) || (out_instr[31:25] == 7'b1100010));
   assign stall_count   = stall_q;
   assign misalign      = misalign_q;

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Two-entry elastic buffer between Instruction Fetch and Instruction Decode. It carries {instruction, pc} pairs with a valid/ready handshake on each side, so an ID stall does not drop a fetched word. A flush from the branch logic discards everything in flight. When no valid entry is present, the output presents the architectural NOP. It also keeps a saturating stall counter and a misaligned-PC flag for debug.

Parameters:
DEPTH, 2, number of buffered entries (power of two, at least 2)
NOP, 32'hC8000000, instruction driven on out_instr when the buffer is empty
CNT_W, 16, width of stall_count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  IF presents a fetched word
in_ready  output  1  buffer can accept; combinational from occupancy (count < DEPTH)
in_instr  input  32  fetched instruction
in_pc  input  32  byte address of in_instr
flush  input  1  discard all entries (taken branch or redirect)
out_valid  output  1  head entry valid for ID
out_ready  input  1  ID consumes the head this cycle
out_instr  output  32  head instruction, or NOP when empty
out_pc  output  32  head pc, or 0 when empty
out_is_branch  output  1  out_valid and out_instr[31:25] is 7'b1100000 (B) or 7'b1100010 (BR)
stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0
misalign  output  1  sticky; set when an accepted in_pc has bits [1:0] not equal to 0

Behaviour:
- Reset (rst=1 at a clock edge):
  - count=0, read and write pointers=0.
  - out_valid=0, out_instr=NOP, out_pc=0, out_is_branch=0.
  - stall_count=0, misalign=0.
  - Reset overrides flush, push and pop in the same cycle.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: circular array of DEPTH {instr, pc} entries with wrapping write and read pointers. count has width log2(DEPTH)+1.
- Latency: an entry pushed at edge N is visible on out_* after edge N. There is no same-cycle bypass from in_* to out_*.
- out_valid = (count != 0).
  - When out_valid=1, out_instr and out_pc come from the entry at the read pointer.
  - When out_valid=0, out_instr=NOP and out_pc=0.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - Full (count=DEPTH): in_ready=0, so push is impossible. A pop while full frees one slot for the next cycle; it does not allow a push in the same cycle.
  - Empty: pop is impossible because out_valid=0.
- Flush (priority below reset, above push and pop):
  - At the edge: count=0, pointers=0, any concurrent push is discarded, any concurrent pop is ignored.
  - Cycle after flush: out_valid=0 and out_instr=NOP.
  - in_ready stays combinational from count, so it may read 1 during the flush cycle; the offered word is still dropped.
- stall_count: +1 at each edge where out_valid=1 and out_ready=0, not counted in a flush cycle. Saturates at all-ones and holds. Cleared only by rst.
- misalign: set at any push edge where in_pc[1:0] is not 0, including the push that is discarded by a concurrent flush. Cleared only by rst.
- Data is never reordered or duplicated; each pushed entry appears exactly once unless it is flushed.
- X-free: no output is X after reset, whatever the storage contents.

Test Plan:
- Reset then idle -> out_valid=0, out_instr=32'hC8000000, out_pc=0, in_ready=1, stall_count=0.
- Push {32'h12345678, pc=0x100} with out_ready=1 -> out_valid=1 next cycle with that word, popped, then out_valid=0 and NOP shown.
- Hold out_ready=0 and push 0x100, 0x104, 0x108 on consecutive cycles -> in_ready=0 after the second push, third word not accepted; stall_count increments by 1 per cycle. Release out_ready -> 0x100 then 0x104 then 0x108 in order, nothing dropped or duplicated.
- Count=1 with simultaneous push and pop for 10 cycles using pc 0x200, 0x204, ... -> count stays 1, outputs follow in order, pointers wrap cleanly.
- Full buffer, then flush=1 together with in_valid=1 -> next cycle out_valid=0, out_instr=NOP, flushed words never appear; a push one cycle later shows with 1-cycle latency.
- Push 32'hC0000010 (B opcode) -> out_is_branch=1 while it is at the head. Push with pc=0x102 -> misalign=1, held until rst. Hold a stall for 65540 cycles -> stall_count holds at 16'hFFFF.
